// File: rtl/mem_sequencer.sv
// Serialises NREAD logical reads plus an optional write per instruction step onto one
// handshaked memory port, pulsing core_step when the core may commit.
module mem_sequencer #(
    parameter int width      = 8,
    parameter int addr_width = 8,
    parameter int nread      = 2,
    parameter bit skip_dup   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [addr_width-1:0] core_addr [1:nread],
    input  logic                  core_wen,
    input  logic [width-1:0]      core_wdata,
    output logic [width-1:0]      core_rdata [1:nread],
    output logic                  core_step,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [width-1:0]      mem_wdata,
    input  logic [width-1:0]      mem_rdata,
    input  logic                  mem_ack
);
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RD,
        ST_WR,
        ST_STEP
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [IDX_W-1:0]                r_idx;
    logic [IDX_W-1:0]                w_idx_next;
    logic [width-1:0]                r_rdata [1:nread];
    logic [nread:1]                  w_sel;
    logic [nread:1]                  w_match;
    logic [nread:0][addr_width-1:0]  w_addr_chain;
    logic [nread+1:1][width-1:0]     w_dup_chain;
    logic [addr_width-1:0]           w_cur_addr;
    logic [width-1:0]                w_dup_data;
    logic                            w_dup;
    logic                            w_last;

    // Address mux is a priority chain upward; the duplicate source chain runs downward
    // so the smallest matching earlier word wins.
    assign w_addr_chain[0]       = '0;
    assign w_dup_chain[nread+1]  = '0;
    assign w_cur_addr            = w_addr_chain[nread];
    assign w_dup_data            = w_dup_chain[1];
    assign w_dup                 = |w_match;
    assign w_last                = (r_idx == IDX_W'(nread));

    for (genvar gi = 1; gi <= nread; gi++) begin : g_word
        assign w_sel[gi]        = (r_idx == IDX_W'(gi));
        assign w_addr_chain[gi] = w_sel[gi] ? core_addr[gi] : w_addr_chain[gi-1];
        assign w_match[gi]      = skip_dup && (IDX_W'(gi) < r_idx)
                                  && (core_addr[gi] == w_cur_addr);
        assign w_dup_chain[gi]  = w_match[gi] ? r_rdata[gi] : w_dup_chain[gi+1];
        assign core_rdata[gi]   = r_rdata[gi];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_rdata[gi] <= '0;
            end else if (r_state == ST_RD && w_sel[gi]) begin
                if (w_dup) begin
                    r_rdata[gi] <= w_dup_data;
                end else if (mem_ack) begin
                    r_rdata[gi] <= mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
            r_idx   <= IDX_W'(1);
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Memory outputs are decoded from state, so the async reset clears them at once.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        core_step    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_state_next = ST_RD;
                w_idx_next   = IDX_W'(1);
            end
            ST_RD: begin
                mem_req  = !w_dup;
                mem_addr = w_dup ? '0 : w_cur_addr;
                if (w_dup || mem_ack) begin
                    if (w_last) begin
                        w_state_next = core_wen ? ST_WR : ST_STEP;
                        w_idx_next   = IDX_W'(1);
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = core_addr[1];
                mem_wdata = core_wdata;
                if (mem_ack) begin
                    w_state_next = ST_STEP;
                end
            end
            ST_STEP: begin
                core_step    = 1'b1;
                w_state_next = ST_RD;
                w_idx_next   = IDX_W'(1);
            end
            default: begin
                w_state_next = ST_INIT;
                w_idx_next   = IDX_W'(1);
            end
        endcase
    end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Memory-port sequencer for the printed-core family, placed between the core datapath and a single-ported, handshaked memory. It generalises the fixed two-read/one-write, single-cycle core memory interface to NREAD logical read ports and variable-latency memory. Each instruction step's reads and optional write are serialised onto one physical port, and a one-cycle `core_step` pulse tells the core when to commit. Duplicate read addresses can optionally be served without a memory access.

## Interface
- `width`, 8, data word width
- `addr_width`, 8, address width
- `nread`, 2, logical read ports from the core; legal range 1..4
- `skip_dup`, 1, 1 = a read whose address equals an earlier read in the same step is copied, not fetched
- `clk`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `core_addr[1:nread]`  in  addr_width each  read addresses; `core_addr[1]` is also the write address
- `core_wen`  in  1  the current step performs a write
- `core_wdata`  in  width  write data; may depend combinationally on `core_rdata`
- `core_rdata[1:nread]`  out  width each  registered read data returned to the core
- `core_step`  out  1  one-cycle pulse; the core commits its instruction on this edge
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  the request is a write
- `mem_addr`  out  addr_width  access address
- `mem_wdata`  out  width  write data
- `mem_rdata`  in  width  read data; valid in the cycle `mem_ack`=1
- `mem_ack`  in  1  access completes at this edge

## Operation
- States: INIT, RD, WR, STEP. Read index `idx` runs 1..nread.
- Reset (asynchronous, `reset`=0):
  - State becomes INIT and `idx`=1.
  - All `core_rdata` = 0.
  - `core_step`, `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are 0 immediately, not at the next edge.
- INIT: one idle cycle, then RD with `idx`=1.
- RD, normal read:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=`core_addr[idx]`, and hold them until `mem_ack`=1.
  - On the edge where `mem_ack`=1, `core_rdata[idx]` <= `mem_rdata`.
- RD, duplicate read (`skip_dup`=1 and `core_addr[idx]`==`core_addr[j]` for some j<idx, smallest such j):
  - `mem_req`=0 for one cycle.
  - `core_rdata[idx]` <= `core_rdata[j]`.
- RD exit: after `idx`=nread completes, go to WR if `core_wen`=1, otherwise go to STEP. Otherwise increment `idx`.
- WR:
  - Drive `mem_req`=1, `mem_we`=1, `mem_addr`=`core_addr[1]`, `mem_wdata`=`core_wdata`, and hold them until `mem_ack`=1.
  - On ack, go to STEP.
- STEP: `core_step`=1 for exactly one cycle, then go to RD with `idx`=1.
- Core inputs must stay stable from STEP exit to the next STEP. The sequencer does not register them.
- `mem_addr` and `mem_wdata` are 0 whenever `mem_req`=0. `mem_we`=0 outside WR.
- `mem_ack` is ignored while `mem_req`=0.
- Reads always complete before the write (read-before-write). A write to an address also read in the same step returns the old data.
- `core_rdata` words not refreshed in a step keep their previous values.

## Timing
- Access latency: 1 cycle minimum (`mem_ack` may be high in the first `mem_req` cycle), otherwise unbounded. The request is never withdrawn except by reset.
- Step length = (fetched reads + skipped reads) + `core_wen` + 1 (STEP), with memory wait cycles added.
  - Minimum: nread+1 cycles with no write; nread+2 with a write.
- Updated `core_rdata[idx]` is visible the cycle after its ack/copy edge. `core_rdata` is stable during WR and STEP.
- First `mem_req` occurs 2 cycles after `reset` deasserts (INIT, then RD).
- Reset mid-access abandons the request combinationally. The memory must tolerate a request dropped without ack.

## Test plan
- Reset release, nread=2, mem[0x10]=0xA5, mem[0x11]=0x3C, `core_addr`={0x10,0x11}, wen=0, ack tied 1 -> `mem_req` rises cycle 2; `core_rdata`={0xA5,0x3C}; `core_step` pulses cycle 4, then every 3 cycles.
- Write step, `core_wen`=1, `core_wdata`=0x77, `core_addr[1]`=0x20 (old value 0x01) -> `core_rdata[1]`=0x01; WR cycle shows `mem_we`=1, `mem_addr`=0x20, `mem_wdata`=0x77; mem[0x20]=0x77 after; step period 4.
- Wait states: ack delayed 3 cycles on each access -> `mem_addr`/`mem_req` held constant throughout; step period 2·3+1=7 (no write).
- Duplicate, skip_dup=1, `core_addr`={0x05,0x05} -> one memory read only; `mem_req`=0 during the second RD cycle; `core_rdata[2]`==`core_rdata[1]`. With skip_dup=0 -> two reads.
- nread=4, addresses {1,2,1,3}, skip_dup=1 -> memory sees reads to 1, 2, 3 only; `core_rdata[3]`==`core_rdata[1]`.
- `reset` asserted while `mem_req`=1 in WR -> `mem_req`, `mem_we`, `mem_addr`, `core_step` and all `core_rdata` are 0 immediately; a later ack is ignored; restart from INIT.
